// File: rtl/wishbone_classic_mem_dev_if.sv
// Wishbone classic bus bundle between a controller (master) and the memory device (slave).
// Signal names follow the device's point of view (_i into the device, _o out of it).
interface wishbone_classic_mem_dev_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                      cyc_i;
  logic                      stb_i;
  logic                      we_i;
  logic [ADDR_WIDTH-1:0]     adr_i;
  logic [DATA_WIDTH-1:0]     dat_i;
  logic [DATA_WIDTH/8-1:0]   sel_i;
  logic [DATA_WIDTH-1:0]     dat_o;
  logic                      ack_o;
  logic                      err_o;
  logic                      rty_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o, rty_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wishbone_classic_mem_dev.sv
// RAM-backed Wishbone classic device with wait states, periodic retry and out-of-range error.
// Protocol properties are compiled in only when WB_CLASSIC_MEM_DEV_FORMAL_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for cyc_i && stb_i; latches the request
// S_WAIT | counting wait states; request drop aborts silently
// S_RESP | one-cycle ack/err/rty; an acked write commits at the end
module wishbone_classic_mem_dev #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1,
  parameter int RTY_PERIOD  = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  wishbone_classic_mem_dev_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (RTY_PERIOD > 1) ? $clog2(RTY_PERIOD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              wcnt_q, wcnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [NB-1:0]           sel_q, sel_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    rty_q, rty_d;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
  logic [CW-1:0]           rcnt_q, rcnt_d;
  logic [DATA_WIDTH-1:0]   ram_q [DEPTH];
  logic [DATA_WIDTH-1:0]   ram_d [DEPTH];
  logic                    req;
  logic                    enter_resp;

  assign req = bus.cyc_i & bus.stb_i;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    sel_d      = sel_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rty_d      = 1'b0;
    rdat_d     = '0;
    rcnt_d     = rcnt_q;
    ram_d      = ram_q;
    enter_resp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d   = bus.we_i;
          adr_d  = bus.adr_i;
          wdat_d = bus.dat_i;
          sel_d  = bus.sel_i;
          wcnt_d = 8'(WAIT_STATES);
          if (WAIT_STATES == 0) enter_resp = 1'b1;
          else                  state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req)                state_d    = S_IDLE;
        else if (wcnt_q == 8'd1) enter_resp = 1'b1;
        else                     wcnt_d     = wcnt_q - 8'd1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (ack_q && we_q) begin
          for (int b = 0; b < NB; b++) begin
            if (sel_q[b]) ram_d[adr_q[IW-1:0]][8*b +: 8] = wdat_q[8*b +: 8];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Selection uses the _d view so the zero-wait path sees the request it is latching now.
    if (enter_resp) begin
      state_d = S_RESP;
      if (32'(adr_d) >= 32'(DEPTH)) begin
        err_d = 1'b1;
      end else if ((RTY_PERIOD != 0) && (rcnt_q == CW'(RTY_PERIOD - 1))) begin
        rty_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (!we_d) rdat_d = ram_q[adr_d[IW-1:0]];
      end
      if (RTY_PERIOD != 0) begin
        rcnt_d = (rcnt_q == CW'(RTY_PERIOD - 1)) ? '0 : rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      rdat_q  <= '0;
      rcnt_q  <= '0;
      ram_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      rdat_q  <= rdat_d;
      rcnt_q  <= rcnt_d;
      ram_q   <= ram_d;
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.err_o = err_q;
  assign bus.rty_o = rty_q;
  assign bus.dat_o = rdat_q;

`ifdef WB_CLASSIC_MEM_DEV_FORMAL_EN
  logic rsp_any;
  assign rsp_any = ack_q | err_q | rty_q;

  default clocking fcb @(posedge clk_i); endclocking
  default disable iff (rst_i);

  a_rsp_needs_req: assert property (rsp_any |-> $past(req));
  a_rsp_onehot:    assert property ($onehot0({ack_q, err_q, rty_q}));
  a_rsp_pulse:     assert property (rsp_any |=> !rsp_any);
  m_stb_in_cyc:    assume property (bus.stb_i |-> bus.cyc_i);
  c_ack:           cover property (ack_q);
  c_err:           cover property (err_q);
  c_rty:           cover property (rty_q);
`endif
endmodule

// File: tb/tb_wishbone_classic_mem_dev.sv
// Scoreboard bench for wishbone_classic_mem_dev: three instances (defaults, retry period 3, four wait states).
module tb_wishbone_classic_mem_dev;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam logic [2:0] K_ACK = 3'b100;
  localparam logic [2:0] K_ERR = 3'b010;
  localparam logic [2:0] K_RTY = 3'b001;

  typedef struct {
    logic [2:0]    kind;
    logic          chk_dat;
    logic [DW-1:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  always #5 clk = ~clk;

  wishbone_classic_mem_dev_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  wishbone_classic_mem_dev_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  wishbone_classic_mem_dev_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  wishbone_classic_mem_dev #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .WAIT_STATES(1), .RTY_PERIOD(0))
    u_dev0 (.clk_i(clk), .rst_i(rst0), .bus(bus0.slave));
  wishbone_classic_mem_dev #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .WAIT_STATES(1), .RTY_PERIOD(3))
    u_dev1 (.clk_i(clk), .rst_i(rst1), .bus(bus1.slave));
  wishbone_classic_mem_dev #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .WAIT_STATES(4), .RTY_PERIOD(0))
    u_dev2 (.clk_i(clk), .rst_i(rst1), .bus(bus2.slave));

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   seen [3]    = '{0, 0, 0};

  function automatic int ws_of(input int d);
    return (d == 2) ? 4 : 1;
  endfunction

  function automatic logic [DW+2:0] outs(input int d);
    case (d)
      0:       return {bus0.ack_o, bus0.err_o, bus0.rty_o, bus0.dat_o};
      1:       return {bus1.ack_o, bus1.err_o, bus1.rty_o, bus1.dat_o};
      default: return {bus2.ack_o, bus2.err_o, bus2.rty_o, bus2.dat_o};
    endcase
  endfunction

  function automatic bit rsp(input int d);
    logic [DW+2:0] o;
    o = outs(d);
    return (o[DW+2:DW] != 3'b000);
  endfunction

  task automatic set_bus(input int d, input logic req, input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [3:0] sel);
    case (d)
      0: begin bus0.cyc_i = req; bus0.stb_i = req; bus0.we_i = we; bus0.adr_i = adr; bus0.dat_i = dat; bus0.sel_i = sel; end
      1: begin bus1.cyc_i = req; bus1.stb_i = req; bus1.we_i = we; bus1.adr_i = adr; bus1.dat_i = dat; bus1.sel_i = sel; end
      default: begin bus2.cyc_i = req; bus2.stb_i = req; bus2.we_i = we; bus2.adr_i = adr; bus2.dat_i = dat; bus2.sel_i = sel; end
    endcase
  endtask

  task automatic push(input int d, input logic [2:0] k, input logic chk, input logic [DW-1:0] dat);
    exp_t e;
    e.kind = k; e.chk_dat = chk; e.dat = dat;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drop_last(input int d);
    case (d)
      0:       if (q0.size() > 0) void'(q0.pop_back());
      1:       if (q1.size() > 0) void'(q1.pop_back());
      default: if (q2.size() > 0) void'(q2.pop_back());
    endcase
  endtask

  task automatic mon(input int d, input logic [2:0] k, input logic [DW-1:0] dat);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (d)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    seen[d]++;
    vectors++;
    if (!have) begin
      miscompares++;
      $display("FAIL unexpected_rsp dut%0d rsp#%0d: got ack/err/rty=%b, none pending", d, seen[d], k);
    end else begin
      if (k !== e.kind) begin
        miscompares++;
        $display("FAIL rsp_kind dut%0d rsp#%0d: got ack/err/rty=%b expected %b", d, seen[d], k, e.kind);
      end
      if (e.chk_dat) begin
        vectors++;
        if (dat !== e.dat) begin
          miscompares++;
          $display("FAIL rsp_data dut%0d rsp#%0d: got dat_o=%h expected %h", d, seen[d], dat, e.dat);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus0.ack_o | bus0.err_o | bus0.rty_o) mon(0, {bus0.ack_o, bus0.err_o, bus0.rty_o}, bus0.dat_o);
    if (bus1.ack_o | bus1.err_o | bus1.rty_o) mon(1, {bus1.ack_o, bus1.err_o, bus1.rty_o}, bus1.dat_o);
    if (bus2.ack_o | bus2.err_o | bus2.rty_o) mon(2, {bus2.ack_o, bus2.err_o, bus2.rty_o}, bus2.dat_o);
  end

  // One transfer: push expectation, hold the request until a response appears, check latency.
  task automatic xfer(input int d, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [3:0] sel, input logic [2:0] k, input logic [DW-1:0] rd, input string name);
    int n;
    bit got;
    push(d, k, !(we && k == K_ACK), rd);
    set_bus(d, 1'b1, we, adr, dat, sel);
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(posedge clk); #1;
      n++;
      got = rsp(d);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_timeout dut%0d: no response after %0d cycles, expected one", name, d, n);
      drop_last(d);
    end else begin
      if (n != ws_of(d) + 1) begin
        miscompares++;
        $display("FAIL %s_latency dut%0d: got %0d cycles expected %0d", name, d, n, ws_of(d) + 1);
      end
      @(posedge clk); #1;
    end
    set_bus(d, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running, expected completion");
    $fatal(1);
  end

  initial begin
    int  n, t1, t2, s;
    bit  got;
    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int d = 0; d < 3; d++) set_bus(d, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (outs(d) !== '0) begin
        miscompares++;
        $display("FAIL reset_outs dut%0d: got %h expected 0", d, outs(d));
      end
    end

    // Defaults: basic access, byte lanes, errors, no aliasing.
    xfer(0, 1'b1, 8'd3,   32'hDEADBEEF, 4'hF, K_ACK, 32'h0,        "wr3");
    xfer(0, 1'b0, 8'd3,   32'h0,        4'hF, K_ACK, 32'hDEADBEEF, "rd3");
    xfer(0, 1'b1, 8'd3,   32'h11223344, 4'h5, K_ACK, 32'h0,        "wr3_sel5");
    xfer(0, 1'b0, 8'd3,   32'h0,        4'hF, K_ACK, 32'hDE22BE44, "rd3_sel5");
    xfer(0, 1'b0, 8'd16,  32'h0,        4'hF, K_ERR, 32'h0,        "rd16_err");
    xfer(0, 1'b1, 8'hFF,  32'h55555555, 4'hF, K_ERR, 32'h0,        "wrff_err");
    xfer(0, 1'b0, 8'd15,  32'h0,        4'hF, K_ACK, 32'h0,        "rd15");
    xfer(0, 1'b0, 8'hFF,  32'h0,        4'hF, K_ERR, 32'h0,        "rdff_err");
    xfer(0, 1'b0, 8'd3,   32'h0,        4'hF, K_ACK, 32'hDE22BE44, "rd3_after_err");

    // Back-to-back: continuous request, responses 3 cycles apart.
    push(0, K_ACK, 1'b1, 32'hDE22BE44);
    push(0, K_ACK, 1'b1, 32'hDE22BE44);
    set_bus(0, 1'b1, 1'b0, 8'd3, '0, 4'hF);
    t1 = -1; t2 = -1; n = 0;
    while (t2 < 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (rsp(0)) begin
        if (t1 < 0) t1 = n;
        else        t2 = n;
      end
    end
    @(posedge clk); #1;
    set_bus(0, 1'b0, 1'b0, '0, '0, '0);
    vectors++;
    if (t1 != 2 || t2 != 5) begin
      miscompares++;
      $display("FAIL b2b_timing dut0: got responses at cycles %0d,%0d expected 2,5", t1, t2);
      while (q0.size() > 0) void'(q0.pop_back());
    end

    // Reset in the RESP cycle of a write: no commit, outputs cleared, RAM cleared.
    push(0, K_ACK, 1'b0, 32'h0);
    set_bus(0, 1'b1, 1'b1, 8'd2, 32'hA5A5A5A5, 4'hF);
    got = 1'b0; n = 0;
    while (!got && n < 50) begin
      @(posedge clk); #1;
      n++;
      got = rsp(0);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL rst_wr_timeout dut0: no response after %0d cycles, expected one", n);
      drop_last(0);
    end
    rst0 = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (outs(0) !== '0) begin
      miscompares++;
      $display("FAIL rst_outs dut0: got %h expected 0", outs(0));
    end
    set_bus(0, 1'b0, 1'b0, '0, '0, '0);
    rst0 = 1'b0;
    @(posedge clk); #1;
    xfer(0, 1'b0, 8'd2, 32'h0, 4'hF, K_ACK, 32'h0, "rd2_after_rst");
    xfer(0, 1'b0, 8'd3, 32'h0, 4'hF, K_ACK, 32'h0, "rd3_after_rst");

    // Retry period 3: pattern ack,ack,rty; err counts and outranks rty; rty writes don't commit.
    for (int i = 0; i < 6; i++)
      xfer(1, 1'b0, 8'd0, 32'h0, 4'hF, (i % 3 == 2) ? K_RTY : K_ACK, 32'h0, "rty_seq");
    xfer(1, 1'b1, 8'd5,  32'h12345678, 4'hF, K_ACK, 32'h0,        "rty_wr5");
    xfer(1, 1'b0, 8'd5,  32'h0,        4'hF, K_ACK, 32'h12345678, "rty_rd5a");
    xfer(1, 1'b1, 8'd5,  32'hFFFFFFFF, 4'hF, K_RTY, 32'h0,        "rty_wr5_retry");
    xfer(1, 1'b0, 8'd5,  32'h0,        4'hF, K_ACK, 32'h12345678, "rty_rd5b");
    xfer(1, 1'b0, 8'd5,  32'h0,        4'hF, K_ACK, 32'h12345678, "rty_rd5c");
    xfer(1, 1'b0, 8'd40, 32'h0,        4'hF, K_ERR, 32'h0,        "rty_err_prio");
    xfer(1, 1'b0, 8'd5,  32'h0,        4'hF, K_ACK, 32'h12345678, "rty_rd5d");

    // Four wait states: latency 5, abort leaves RAM untouched.
    xfer(2, 1'b1, 8'd7, 32'h0BADF00D, 4'hF, K_ACK, 32'h0,        "ws4_wr7");
    xfer(2, 1'b0, 8'd7, 32'h0,        4'hF, K_ACK, 32'h0BADF00D, "ws4_rd7");
    s = seen[2];
    set_bus(2, 1'b1, 1'b1, 8'd1, 32'hCAFEF00D, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    set_bus(2, 1'b0, 1'b0, '0, '0, '0);
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (seen[2] != s) begin
      miscompares++;
      $display("FAIL abort_no_rsp dut2: got %0d responses expected 0", seen[2] - s);
    end
    xfer(2, 1'b0, 8'd1, 32'h0, 4'hF, K_ACK, 32'h0,        "ws4_rd1_after_abort");
    xfer(2, 1'b0, 8'd7, 32'h0, 4'hF, K_ACK, 32'h0BADF00D, "ws4_rd7_again");

    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      miscompares++;
      $display("FAIL pending_exp: got %0d unanswered transfers expected 0", q0.size() + q1.size() + q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wishbone_classic_mem_dev.md
# wishbone_classic_mem_dev

A parametrised Wishbone classic device model that replaces the property-only fake device. It is a real RAM-backed responder. It has a configurable address range, wait-state count and periodic retry injection, and it returns an error for out-of-range accesses. It sits on the device side of any Wishbone classic controller under test, in simulation benches and formal harnesses, and gives that controller realistic, deterministic responses.

## Interface
Parameters:
- ADDR_WIDTH, default 8: width of the word address `adr_i`.
- DATA_WIDTH, default 32: data width. Must be a multiple of 8.
- DEPTH, default 16: number of words of backing RAM. Must be ≤ 2^ADDR_WIDTH.
- WAIT_STATES, default 1: cycles inserted between request detection and response. Range 0..255.
- RTY_PERIOD, default 0: every RTY_PERIOD-th response is a retry. 0 disables retries.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- cyc_i  in  1  bus cycle in progress.
- stb_i  in  1  strobe.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  ADDR_WIDTH  word address.
- dat_i  in  DATA_WIDTH  write data.
- sel_i  in  DATA_WIDTH/8  byte-lane enables.
- dat_o  out  DATA_WIDTH  read data.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination.
- rty_o  out  1  retry termination.

## Operation
- Request = cyc_i && stb_i. All outputs are registered.
- States:
  - IDLE:
    - On a request, latch we_i/adr_i/dat_i/sel_i and load the wait counter with WAIT_STATES.
    - If WAIT_STATES = 0, go to RESP; otherwise go to WAIT.
  - WAIT:
    - Decrement the counter.
    - When the counter reaches 1 and the request is still high, go to RESP.
    - If the request drops, go to IDLE with no response (abort).
  - RESP:
    - Exactly one of ack_o/err_o/rty_o is high for one cycle.
    - Next state is IDLE unconditionally.
- Response selection, evaluated on entry to RESP, in priority order:
  1. Latched address ≥ DEPTH: err_o.
  2. RTY_PERIOD ≠ 0 and the response counter equals RTY_PERIOD−1: rty_o.
  3. Otherwise: ack_o.
- Response counter:
  - Increments on every response (ack, err or rty).
  - Wraps to 0 after RTY_PERIOD−1.
  - Held at 0 when RTY_PERIOD = 0.
- Writes:
  - Commit only on an ack, at the clock edge that ends the RESP cycle.
  - Only byte lanes with sel_i[n] = 1 are updated.
  - err and rty never modify the RAM.
- Reads:
  - dat_o = RAM[latched address] during an ack cycle.
  - dat_o = 0 in all other cycles, including err and rty cycles.
- Request dropping during RESP: the response still completes and a pending write still commits. The controller owns that violation.
- Back-to-back: if the request is still high in the IDLE cycle after RESP, it is treated as a new request.

## Timing
- Reset values: state IDLE, ack_o/err_o/rty_o = 0, dat_o = 0, response counter = 0, all RAM words = 0.
- Latency: request first high at cycle t → response at cycle t+1+WAIT_STATES.
- Throughput: one transfer per WAIT_STATES+2 cycles under continuous requests.
- Reset asserted mid-transaction:
  - Next cycle is IDLE with all outputs 0.
  - No write commits, including a write in RESP on the same edge as reset.
  - RAM is cleared.
- Address wrap: no aliasing. Any adr_i ≥ DEPTH errors, including all-ones.

## Configuration
- WB_CLASSIC_MEM_DEV_FORMAL_EN defined: compiles in the protocol properties under a default clocking on clk_i, disabled while rst_i is high.
  - Assertions: no response without request; at most one of ack/err/rty high; every response is a single-cycle pulse.
  - Assumption: stb_i implies cyc_i.
  - Cover: ack, err and rty each reachable.
- Not defined: no properties are compiled. The RTL behaviour is identical in both cases.

## Test plan
- Basic access, defaults: write 0xDEADBEEF to address 3 with sel 0xF, then read address 3 → ack_o at t+2 for each access; read returns 0xDEADBEEF.
- Byte enables: over 0xDEADBEEF at address 3, write 0x11223344 with sel 0x5, then read address 3 → 0xDE22BE44.
- Error termination: read address 16, DEPTH = 16 → err_o for one cycle, dat_o = 0, RAM unchanged.
- Retry injection, RTY_PERIOD = 3: six consecutive reads → responses ack, ack, rty, ack, ack, rty.
- Abort: WAIT_STATES = 4; stb_i drops 2 cycles after a write to address 1 → no response, and address 1 reads back 0.
- Reset mid-operation: assert rst_i in the RESP cycle of a write of 0xA5A5A5A5 to address 2 → outputs 0 on the next cycle, and address 2 reads back 0.
